// File: rtl/cpu15_pkg.sv
// Shared definitions for the cpu15 decode stage: opcode map, default field widths,
// decoded-entry layout and the opcode classifier.
package cpu15_pkg;

  localparam int unsigned DEF_OPC_W  = 4;
  localparam int unsigned DEF_REG_W  = 3;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_SL  = 4'h5;
  localparam logic [3:0] OP_SR  = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_LDL = 4'h8;
  localparam logic [3:0] OP_LDH = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_JE  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LD  = 4'hD;
  localparam logic [3:0] OP_ST  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic is_alu;
    logic is_ldi;
    logic is_mem;
    logic is_branch;
    logic is_halt;
  } dec_flags_t;

  typedef struct packed {
    logic [DEF_OPC_W-1:0]  opcode;
    logic [DEF_REG_W-1:0]  reg_a;
    logic [DEF_REG_W-1:0]  reg_b;
    logic [DEF_DATA_W-1:0] data;
    dec_flags_t            flags;
  } dec_entry_t;

  // Opcode is zero-extended by the caller so that wide opcodes (>= 16) fall through
  // with no class set.
  function automatic dec_flags_t classify(input logic [31:0] opc);
    dec_flags_t f;
    f = '0;
    if (opc <= 32'(OP_SRA) || opc == 32'(OP_CMP)) begin
      f.is_alu = 1'b1;
    end else if (opc == 32'(OP_LDL) || opc == 32'(OP_LDH)) begin
      f.is_ldi = 1'b1;
    end else if (opc == 32'(OP_LD) || opc == 32'(OP_ST)) begin
      f.is_mem = 1'b1;
    end else if (opc == 32'(OP_JE) || opc == 32'(OP_JMP)) begin
      f.is_branch = 1'b1;
    end else if (opc == 32'(OP_HLT)) begin
      f.is_halt = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational split of an instruction word into its fields plus class flags.
module decode_fields
  import cpu15_pkg::*;
#(
  parameter int unsigned OPC_W  = DEF_OPC_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned INST_W = OPC_W + REG_W + DATA_W
) (
  input  logic [INST_W-1:0] word_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [REG_W-1:0]  reg_a_o,
  output logic [REG_W-1:0]  reg_b_o,
  output logic [DATA_W-1:0] data_o,
  output dec_flags_t        flags_o
);

  // reg_b deliberately overlaps the top of the data field.
  always_comb begin
    opcode_o = word_i[INST_W-1 -: OPC_W];
    reg_a_o  = word_i[DATA_W+REG_W-1 -: REG_W];
    reg_b_o  = word_i[DATA_W-1 -: REG_W];
    data_o   = word_i[DATA_W-1:0];
    flags_o  = classify(32'(word_i[INST_W-1 -: OPC_W]));
  end

endmodule

// File: rtl/decode_pipe.sv
// cpu15 decode stage: valid/ready instruction decode with a two-entry skid buffer,
// branch flush, halt latch and accepted-instruction counter.
module decode_pipe
  import cpu15_pkg::*;
#(
  parameter int unsigned OPC_W  = DEF_OPC_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned INST_W = OPC_W + REG_W + DATA_W
) (
  input  logic              CLK_DC,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [INST_W-1:0] PROM_OUT,
  input  logic              FLUSH,
  input  logic              RESUME,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [OPC_W-1:0]  OP_CODE,
  output logic [REG_W-1:0]  REG_A,
  output logic [REG_W-1:0]  REG_B,
  output logic [DATA_W-1:0] OP_DATA,
  output logic              IS_ALU,
  output logic              IS_LDI,
  output logic              IS_MEM,
  output logic              IS_BRANCH,
  output logic              IS_HALT,
  output logic              HALTED,
  output logic [CNT_W-1:0]  DEC_COUNT
);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  reg_a;
    logic [REG_W-1:0]  reg_b;
    logic [DATA_W-1:0] data;
    dec_flags_t        flags;
  } entry_t;

  logic [OPC_W-1:0]  in_opcode;
  logic [REG_W-1:0]  in_reg_a;
  logic [REG_W-1:0]  in_reg_b;
  logic [DATA_W-1:0] in_data;
  dec_flags_t        in_flags;
  entry_t            in_ent;

  entry_t            main_q, main_d, skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              halt_pending_q, halt_pending_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, consume;

  decode_fields #(
    .OPC_W  (OPC_W),
    .REG_W  (REG_W),
    .DATA_W (DATA_W)
  ) u_fields (
    .word_i   (PROM_OUT),
    .opcode_o (in_opcode),
    .reg_a_o  (in_reg_a),
    .reg_b_o  (in_reg_b),
    .data_o   (in_data),
    .flags_o  (in_flags)
  );

  assign in_ent = {in_opcode, in_reg_a, in_reg_b, in_data, in_flags};

  // Ready depends only on registered state plus FLUSH; OUT_READY never reaches it.
  assign IN_READY = !skid_valid_q && !halted_q && !halt_pending_q && !FLUSH;
  assign accept   = IN_VALID && IN_READY;
  assign consume  = main_valid_q && OUT_READY;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (FLUSH) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume && skid_valid_q) begin
      // Skid full implies nothing was accepted this cycle.
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (consume || !main_valid_q) begin
      main_valid_d = accept;
      if (accept) begin
        main_d = in_ent;
      end
    end else if (accept) begin
      skid_d       = in_ent;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    halted_d       = halted_q;
    halt_pending_d = halt_pending_q;
    if (RESUME) begin
      halted_d       = 1'b0;
      halt_pending_d = 1'b0;
    end else begin
      halted_d       = halted_q || halt_pending_q;
      halt_pending_d = accept && in_ent.flags.is_halt;
    end
    cnt_d = cnt_q + CNT_W'(accept);
  end

  always_ff @(posedge CLK_DC or posedge RESET) begin
    if (RESET) begin
      main_q         <= '0;
      skid_q         <= '0;
      main_valid_q   <= 1'b0;
      skid_valid_q   <= 1'b0;
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      main_q         <= main_d;
      skid_q         <= skid_d;
      main_valid_q   <= main_valid_d;
      skid_valid_q   <= skid_valid_d;
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
      cnt_q          <= cnt_d;
    end
  end

  assign OUT_VALID = main_valid_q;
  assign OP_CODE   = main_q.opcode;
  assign REG_A     = main_q.reg_a;
  assign REG_B     = main_q.reg_b;
  assign OP_DATA   = main_q.data;
  assign IS_ALU    = main_valid_q && main_q.flags.is_alu;
  assign IS_LDI    = main_valid_q && main_q.flags.is_ldi;
  assign IS_MEM    = main_valid_q && main_q.flags.is_mem;
  assign IS_BRANCH = main_valid_q && main_q.flags.is_branch;
  assign IS_HALT   = main_valid_q && main_q.flags.is_halt;
  assign HALTED    = halted_q;
  assign DEC_COUNT = cnt_q;

endmodule
